// File: rtl/seq_detect_ctrl.sv
// Serial pattern scanner with IDLE/ARMED/DONE control, valid/ready event output,
// sticky overflow flag and optional match counter (macro SEQ_DETECT_CTRL_COUNT_EN).
module seq_detect_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             seq_valid,
  input  logic             seq_in,
  output logic             busy,
  output logic             det_valid,
  input  logic             det_ready,
  output logic             det_ovf,
  output logic [CNT_W-1:0] det_count,
  output logic [1:0]       dbg_state
);

  // Event handshake: an event is held on det_valid until a cycle with
  // det_valid && det_ready; a match in that same cycle keeps det_valid high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pat_q;
  logic [3:0] len_q;
  logic       ovl_q, one_q;
  logic [7:0] hist_q;
  logic [3:0] fill_q;
  logic [7:0] hist_upd;
  logic [7:0] mask;
  logic [3:0] fill_upd;
  logic [3:0] len_clamped;
  logic       arm;
  logic       match;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == 4'd0)      len_clamped = 4'd1;
    else if (cfg_len > 4'd8)  len_clamped = 4'd8;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) mask[i] = (4'(i) < len_q);
  end

  // Match is judged on the history/fill values as they will be after this bit.
  assign hist_upd = {hist_q[6:0], seq_in};
  assign fill_upd = (fill_q >= len_q) ? len_q : fill_q + 4'd1;
  assign match    = (state == S_ARMED) && seq_valid && (fill_upd == len_q) &&
                    (((hist_upd ^ pat_q) & mask) == 8'h00);
  assign arm      = start && !stop && (state != S_ARMED);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: begin
        if (stop)                state_nxt = S_IDLE;
        else if (match && one_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= 8'h00;
      len_q <= 4'd1;
      ovl_q <= 1'b0;
      one_q <= 1'b0;
    end else if (state == S_IDLE && cfg_we) begin
      pat_q <= cfg_pattern;
      len_q <= len_clamped;
      ovl_q <= cfg_overlap;
      one_q <= cfg_oneshot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 8'h00;
      fill_q <= 4'd0;
    end else if (arm) begin
      hist_q <= 8'h00;
      fill_q <= 4'd0;
    end else if (state == S_ARMED && seq_valid) begin
      if (match && !ovl_q) begin
        hist_q <= 8'h00;
        fill_q <= 4'd0;
      end else begin
        hist_q <= hist_upd;
        fill_q <= fill_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_valid <= 1'b0;
      det_ovf   <= 1'b0;
    end else if (arm) begin
      det_valid <= 1'b0;
      det_ovf   <= 1'b0;
    end else if (match) begin
      det_valid <= 1'b1;
      if (det_valid && !det_ready) det_ovf <= 1'b1;
    end else if (det_valid && det_ready) begin
      det_valid <= 1'b0;
    end
  end

`ifdef SEQ_DETECT_CTRL_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   count_q <= '0;
    else if (arm)                   count_q <= '0;
    else if (match && !(&count_q))  count_q <= count_q + 1'b1;
  end

  assign det_count = count_q;
`else
  assign det_count = '0;
`endif

  assign busy      = (state == S_ARMED);
  assign dbg_state = state;

endmodule
